// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin sequencer sharing one uart_tx among NUM_CH byte
//            sources, with packet locking and between-frame divisor updates.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEFAULT_CNT = 434,
  parameter int LOCK_TMO    = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_CH-1:0]            req_last,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [15:0]                  cfg_cnt,
  output logic [15:0]                  uart_cnt,
  output logic                         uart_flag,
  output logic [DATA_WIDTH-1:0]        uart_data,
  input  logic                         uart_busy,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  output logic                         locked,
  output logic                         ack_err
);

  localparam int c_IDW   = $clog2(NUM_CH);
  localparam int c_TMO_W = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = (LOCK_TMO > 0) ? c_TMO_W'(LOCK_TMO - 1) : '0;
  localparam logic [c_IDW-1:0]   c_LAST_CH  = c_IDW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_ARB       = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_IDW-1:0]      r_last_grant, r_grant_id;
  logic                  r_locked;
  logic [c_TMO_W-1:0]    r_idle;
  logic [1:0]            r_ack_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_cnt;

  logic [NUM_CH-1:0]     w_cand;
  logic [c_IDW-1:0]      w_ptr, w_winner;
  logic                  w_found, w_accept, w_idle_tick, w_win_last;
  logic [DATA_WIDTH-1:0] w_byte;

  // A held packet lock narrows the candidate set to the locked channel
  always_comb begin
    w_cand = req_valid;
    if (r_locked) w_cand = req_valid & (NUM_CH'(1) << r_grant_id);
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_ptr    = (r_last_grant == c_LAST_CH) ? '0 : r_last_grant + c_IDW'(1);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_cand[w_ptr]) begin
        w_found  = 1'b1;
        w_winner = w_ptr;
      end
      w_ptr = (w_ptr == c_LAST_CH) ? '0 : w_ptr + c_IDW'(1);
    end
  end

  always_comb begin
    w_byte     = '0;
    w_win_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_winner == c_IDW'(k)) begin
        w_byte     = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        w_win_last = req_last[k];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    ack_err     = 1'b0;
    case (r_state)
      S_ARB: begin
        if (!uart_busy && w_found) begin
          w_accept            = 1'b1;
          req_ready[w_winner] = 1'b1;
          w_state_nxt         = S_LAUNCH;
        end
      end
      S_LAUNCH:    w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (uart_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_ack_cnt == 2'd3) begin
          ack_err     = 1'b1;
          w_state_nxt = S_ARB;
        end
      end
      S_WAIT_DONE: if (!uart_busy) w_state_nxt = S_ARB;
      default:     w_state_nxt = S_ARB;
    endcase
  end

  assign w_idle_tick = (LOCK_TMO != 0) && (r_state == S_ARB) && r_locked && !req_valid[r_grant_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ARB;
      r_last_grant <= c_LAST_CH;
      r_grant_id   <= '0;
      r_locked     <= 1'b0;
      r_idle       <= '0;
      r_ack_cnt    <= '0;
      r_data       <= '0;
      r_cnt        <= 16'(DEFAULT_CNT);
    end else begin
      r_state <= w_state_nxt;
      // Divisor only moves while no frame is in flight; zero means keep
      if (r_state == S_ARB && cfg_cnt != 16'd0) r_cnt <= cfg_cnt;
      if (r_state == S_WAIT_ACK) r_ack_cnt <= r_ack_cnt + 2'd1;
      else                       r_ack_cnt <= '0;
      if (w_accept) begin
        r_data       <= w_byte;
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
        r_locked     <= !w_win_last;
        r_idle       <= '0;
      end else if (w_idle_tick) begin
        if (r_idle == c_TMO_LAST) begin
          r_locked <= 1'b0;
          r_idle   <= '0;
        end else begin
          r_idle <= r_idle + c_TMO_W'(1);
        end
      end
    end
  end

  assign uart_flag = (r_state == S_LAUNCH);
  assign uart_cnt  = r_cnt;
  assign uart_data = r_data;
  assign grant_id  = r_grant_id;
  assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Directed self-checking bench for uart_tx_arb with a uart_tx
//            busy model (busy rises the cycle after the launch pulse).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int c_NCH = 4;
  localparam int c_DW  = 8;

  logic                   clk;
  logic                   rst_n;
  logic [c_NCH-1:0]       req_valid;
  logic [c_NCH*c_DW-1:0]  req_data;
  logic [c_NCH-1:0]       req_last;
  logic [c_NCH-1:0]       req_ready;
  logic [15:0]            cfg_cnt;
  logic [15:0]            uart_cnt;
  logic                   uart_flag;
  logic [c_DW-1:0]        uart_data;
  logic                   uart_busy;
  logic [1:0]             grant_id;
  logic                   locked;
  logic                   ack_err;

  uart_tx_arb #(
    .NUM_CH(c_NCH), .DATA_WIDTH(c_DW), .DEFAULT_CNT(434), .LOCK_TMO(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cfg_cnt(cfg_cnt),
    .uart_cnt(uart_cnt), .uart_flag(uart_flag), .uart_data(uart_data),
    .uart_busy(uart_busy), .grant_id(grant_id), .locked(locked), .ack_err(ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx stand-in: busy for three cycles starting the cycle after the flag
  logic r_busy_en;
  int   r_busy_cnt;
  always @(posedge clk) begin
    if (r_busy_en && uart_flag) r_busy_cnt <= 3;
    else if (r_busy_cnt != 0)   r_busy_cnt <= r_busy_cnt - 1;
  end
  assign uart_busy = (r_busy_cnt != 0);

  int n_vec, n_err;
  int rec_gid[$];
  int rec_data[$];
  int rec_lock[$];
  logic [7:0] q_data[c_NCH][8];
  logic       q_last[c_NCH][8];
  int         q_len[c_NCH];
  int         q_ptr[c_NCH];

  int exp_b_gid[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_b_data[8] = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23};
  int exp_c_gid[7]  = '{0, 1, 2, 2, 2, 3, 0};
  int exp_c_data[7] = '{'hA0, 'hB0, 'hC0, 'hC1, 'hC2, 'hD0, 'hA1};
  int exp_c_lock[7] = '{0, 0, 1, 1, 0, 0, 0};

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (uart_flag) begin
      rec_gid.push_back(int'(grant_id));
      rec_data.push_back(int'(uart_data));
      rec_lock.push_back(int'(locked));
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < c_NCH; i++) begin
      q_len[i] = 0;
      q_ptr[i] = 0;
    end
    rec_gid.delete();
    rec_data.delete();
    rec_lock.delete();
  endtask

  task automatic push_byte(input int ch, input logic [7:0] d, input logic l);
    q_data[ch][q_len[ch]] = d;
    q_last[ch][q_len[ch]] = l;
    q_len[ch]++;
  endtask

  task automatic drive_q();
    for (int i = 0; i < c_NCH; i++) begin
      if (q_ptr[i] < q_len[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*c_DW +: c_DW] = q_data[i][q_ptr[i]];
        req_last[i]           = q_last[i][q_ptr[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // Presents queued bytes, retiring each one the cycle after its ready
  task automatic run_traffic(input int target, input int budget);
    logic [c_NCH-1:0] seen;
    int n;
    seen = '0;
    n    = 0;
    while (rec_gid.size() < target && n < budget) begin
      tick();
      n++;
      for (int i = 0; i < c_NCH; i++) if (seen[i]) q_ptr[i]++;
      drive_q();
      #1;
      seen = req_ready;
    end
    chk_val("traffic_frames", 32'(rec_gid.size()), 32'(target));
  endtask

  task automatic wait_idle();
    int n;
    logic timed_out;
    timed_out = 1'b1;
    for (n = 0; n < 50; n++) begin
      tick();
      if (!uart_busy && !uart_flag) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk_val("idle_wait_timeout", 32'(timed_out), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    cfg_cnt    = 16'd0;
    r_busy_en  = 1'b1;
    r_busy_cnt = 0;
    clear_q();

    repeat (2) tick();
    chk_val("rst_ready", 32'(req_ready), 32'd0);
    chk_val("rst_flag",  32'(uart_flag), 32'd0);
    chk_val("rst_data",  32'(uart_data), 32'd0);
    chk_val("rst_cnt",   32'(uart_cnt),  32'd434);
    chk_val("rst_gid",   32'(grant_id),  32'd0);
    chk_val("rst_lock",  32'(locked),    32'd0);
    chk_val("rst_ackerr", 32'(ack_err),  32'd0);
    rst_n = 1'b1;
    tick();

    // Single ch0 byte: ready in the accept cycle, flag the next
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    req_last = 4'b0001;
    #1;
    chk_val("A_ready", 32'(req_ready), 32'h1);
    tick();
    chk_val("A_flag",  32'(uart_flag), 32'd1);
    chk_val("A_data",  32'(uart_data), 32'hA5);
    chk_val("A_ready_low", 32'(req_ready), 32'd0);
    req_valid = '0;
    tick();
    chk_val("A_flag_pulse", 32'(uart_flag), 32'd0);
    wait_idle();

    // Four channels, two bytes each, all packets single-byte
    do_reset();
    clear_q();
    for (int i = 0; i < c_NCH; i++) begin
      push_byte(i, 8'(8'h10 + i), 1'b1);
      push_byte(i, 8'(8'h20 + i), 1'b1);
    end
    run_traffic(8, 200);
    wait_idle();
    for (int k = 0; k < 8 && k < rec_gid.size(); k++) begin
      chk_val("B_gid",  32'(rec_gid[k]),  32'(exp_b_gid[k]));
      chk_val("B_data", 32'(rec_data[k]), 32'(exp_b_data[k]));
    end

    // ch2 three-byte packet holds the grant against waiting channels
    do_reset();
    clear_q();
    push_byte(0, 8'hA0, 1'b1);
    push_byte(0, 8'hA1, 1'b1);
    push_byte(1, 8'hB0, 1'b1);
    push_byte(2, 8'hC0, 1'b0);
    push_byte(2, 8'hC1, 1'b0);
    push_byte(2, 8'hC2, 1'b1);
    push_byte(3, 8'hD0, 1'b1);
    run_traffic(7, 200);
    wait_idle();
    for (int k = 0; k < 7 && k < rec_gid.size(); k++) begin
      chk_val("C_gid",  32'(rec_gid[k]),  32'(exp_c_gid[k]));
      chk_val("C_data", 32'(rec_data[k]), 32'(exp_c_data[k]));
      chk_val("C_lock", 32'(rec_lock[k]), 32'(exp_c_lock[k]));
    end

    // Lock on idle ch1 expires after 16 ARB cycles, then ch0 wins
    do_reset();
    clear_q();
    push_byte(1, 8'h61, 1'b0);
    run_traffic(1, 50);
    if (rec_gid.size() > 0) begin
      chk_val("D_gid",  32'(rec_gid[0]),  32'd1);
      chk_val("D_lock", 32'(rec_lock[0]), 32'd1);
    end
    req_valid = 4'b0001;
    req_data[7:0] = 8'h40;
    req_last = 4'b0001;
    repeat (20) tick();
    chk_val("D_lock_held", 32'(locked), 32'd1);
    tick();
    chk_val("D_lock_drop", 32'(locked), 32'd0);
    #1;
    chk_val("D_ready0", 32'(req_ready), 32'h1);
    tick();
    chk_val("D_flag", 32'(uart_flag), 32'd1);
    chk_val("D_gid0", 32'(grant_id),  32'd0);
    req_valid = '0;
    wait_idle();

    // Divisor request during a frame waits until the frame completes
    req_valid = 4'b0001;
    req_data[7:0] = 8'h3C;
    req_last = 4'b0001;
    tick();
    chk_val("E_flag", 32'(uart_flag), 32'd1);
    req_valid = '0;
    cfg_cnt = 16'd868;
    tick();
    chk_val("E_cnt_busy", 32'(uart_cnt), 32'd434);
    repeat (3) tick();
    chk_val("E_cnt_done", 32'(uart_cnt), 32'd434);
    tick();
    tick();
    chk_val("E_cnt_new", 32'(uart_cnt), 32'd868);
    cfg_cnt = 16'd0;
    repeat (2) tick();
    chk_val("E_cnt_zero_ign", 32'(uart_cnt), 32'd868);

    // No busy response: ack_err on the fourth WAIT_ACK cycle
    r_busy_en = 1'b0;
    req_valid = 4'b1000;
    req_data[31:24] = 8'h77;
    req_last = 4'b1000;
    #1;
    chk_val("F_ready3", 32'(req_ready), 32'h8);
    tick();
    chk_val("F_flag", 32'(uart_flag), 32'd1);
    chk_val("F_gid",  32'(grant_id),  32'd3);
    req_valid = '0;
    repeat (3) tick();
    chk_val("F_ackerr_early", 32'(ack_err), 32'd0);
    tick();
    chk_val("F_ackerr", 32'(ack_err), 32'd1);
    tick();
    chk_val("F_ackerr_pulse", 32'(ack_err), 32'd0);
    r_busy_en = 1'b1;
    req_valid = 4'b0100;
    req_data[23:16] = 8'h5A;
    req_last = 4'b0000;
    #1;
    chk_val("F_back_in_arb", 32'(req_ready), 32'h4);
    tick();
    chk_val("G_flag", 32'(uart_flag), 32'd1);
    req_valid = '0;
    repeat (2) tick();
    chk_val("G_locked_pre", 32'(locked), 32'd1);

    // Reset asserted while uart_tx is still busy
    rst_n = 1'b0;
    #1;
    chk_val("G_ready", 32'(req_ready), 32'd0);
    chk_val("G_flag0", 32'(uart_flag), 32'd0);
    chk_val("G_data",  32'(uart_data), 32'd0);
    chk_val("G_cnt",   32'(uart_cnt),  32'd434);
    chk_val("G_gid",   32'(grant_id),  32'd0);
    chk_val("G_lock",  32'(locked),    32'd0);
    chk_val("G_ackerr", 32'(ack_err),  32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
